// File: rtl/memory_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package memory_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: one-hot grant, pointer chooses the winner only on contention.
module rr_arbiter2 (
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   output logic [1:0] gnt_o
);

   // ptr_i = 1 favours requester 1; a lone request always wins.
   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) begin
         gnt_o = ptr_i ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates two requesters onto one external memory port, one 3-cycle access at a time.
module memory_arbiter
   import memory_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_write_enable,
   input  logic [DATA_W-1:0] mem_data_out,
   output state_e            dbg_state_o
);

   state_e            state_q, state_d;
   logic              ptr_q, ptr_d;
   logic              sel_q, sel_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic [1:0]        gnt;

   rr_arbiter2 u_rr (
      .req_i ({req1, req0}),
      .ptr_i (ptr_q),
      .gnt_o (gnt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         sel_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         sel_q    <= sel_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      sel_d    = sel_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         IDLE: begin
            if (gnt != 2'b00) begin
               state_d = ACCESS;
               sel_d   = gnt[1];
               ptr_d   = gnt[0];
               we_d    = gnt[1] ? we1    : we0;
               addr_d  = gnt[1] ? addr1  : addr0;
               wdata_d = gnt[1] ? wdata1 : wdata0;
            end
         end
         ACCESS: begin
            state_d = RESPOND;
            // Read data is latched as RESPOND begins so rdata is already valid alongside ack.
            if (!we_q) begin
               if (sel_q) rdata1_d = mem_data_out;
               else       rdata0_d = mem_data_out;
            end
         end
         RESPOND: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Strobes decode straight from state so an asynchronous reset kills them at once.
   assign mem_write_enable = (state_q == ACCESS) && we_q;
   assign ack0             = (state_q == RESPOND) && !sel_q;
   assign ack1             = (state_q == RESPOND) && sel_q;
   assign busy             = (state_q != IDLE);
   assign mem_address      = addr_q;
   assign mem_data_in      = wdata_q;
   assign rdata0           = rdata0_q;
   assign rdata1           = rdata1_q;
   assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench: directed scenarios plus random transactions against a transaction-level model.
module tb_memory_arbiter;

   logic       clk;
   logic       reset_n;
   logic       req0, req1, we0, we1;
   logic [3:0] addr0, addr1, wdata0, wdata1;
   logic       ack0, ack1, busy, mem_write_enable;
   logic [3:0] rdata0, rdata1, mem_address, mem_data_in, mem_data_out;
   memory_pkg::state_e dbg_state;

   logic [3:0] mem [16] = '{default: 4'h0};
   logic [3:0] exp_mem [16] = '{default: 4'h0};
   logic [3:0] exp_rd [2] = '{default: 4'h0};
   int         pref = 0;
   int         checks = 0;
   int         errors = 0;

   memory_arbiter #(.ADDR_W(4), .DATA_W(4)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .req0             (req0),
      .req1             (req1),
      .we0              (we0),
      .we1              (we1),
      .addr0            (addr0),
      .addr1            (addr1),
      .wdata0           (wdata0),
      .wdata1           (wdata1),
      .ack0             (ack0),
      .ack1             (ack1),
      .rdata0           (rdata0),
      .rdata1           (rdata1),
      .busy             (busy),
      .mem_address      (mem_address),
      .mem_data_in      (mem_data_in),
      .mem_write_enable (mem_write_enable),
      .mem_data_out     (mem_data_out),
      .dbg_state_o      (dbg_state)
   );

   // Memory unit: combinational read, write on the rising edge.
   assign mem_data_out = mem[mem_address];
   always @(posedge clk) begin
      if (mem_write_enable) mem[mem_address] <= mem_data_in;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_ack"},   {ack1, ack0}, 0);
      check({tag, "_we"},    mem_write_enable, 0);
      check({tag, "_addr"},  mem_address, 0);
      check({tag, "_din"},   mem_data_in, 0);
      check({tag, "_rd0"},   rdata0, 0);
      check({tag, "_rd1"},   rdata1, 0);
      check({tag, "_state"}, dbg_state, 0);
   endtask

   // Called at a falling edge with the arbiter idle; returns at a falling edge with it idle again.
   task automatic run_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                          input logic [3:0] a0, input logic [3:0] a1,
                          input logic [3:0] d0, input logic [3:0] d1, input int mode);
      int         win;
      logic       e_we;
      logic [3:0] e_a, e_d;
      req0 = r0; req1 = r1; we0 = w0; we1 = w1;
      addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
      if (r0 && r1) win = pref;
      else if (r0)  win = 0;
      else if (r1)  win = 1;
      else          win = -1;
      check("idle_busy", busy, 0);
      @(posedge clk); @(negedge clk);
      if (win < 0) begin
         check("noreq_busy", busy, 0);
         check("noreq_ack", {ack1, ack0}, 0);
         return;
      end
      pref = 1 - win;
      e_we = (win == 1) ? w1 : w0;
      e_a  = (win == 1) ? a1 : a0;
      e_d  = (win == 1) ? d1 : d0;
      check("acc_busy", busy, 1);
      check("acc_we",   mem_write_enable, e_we);
      check("acc_addr", mem_address, e_a);
      check("acc_din",  mem_data_in, e_d);
      check("acc_ack",  {ack1, ack0}, 0);
      if (e_we) exp_mem[e_a] = e_d;
      else      exp_rd[win]  = exp_mem[e_a];
      case (mode)
         1: begin
            req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
            we0 = 1'($urandom_range(0, 1));  we1 = 1'($urandom_range(0, 1));
            addr0 = 4'($urandom_range(0, 15)); addr1 = 4'($urandom_range(0, 15));
            wdata0 = 4'($urandom_range(0, 15)); wdata1 = 4'($urandom_range(0, 15));
         end
         2: begin
            addr0 = 4'h2; wdata0 = 4'hF;
         end
         default: begin
            req0 = 1'b0; req1 = 1'b0;
         end
      endcase
      @(posedge clk); @(negedge clk);
      check("rsp_ack0", ack0, win == 0);
      check("rsp_ack1", ack1, win == 1);
      check("rsp_we",   mem_write_enable, 0);
      check("rsp_busy", busy, 1);
      check("rsp_addr", mem_address, e_a);
      check("rsp_rd0",  rdata0, exp_rd[0]);
      check("rsp_rd1",  rdata1, exp_rd[1]);
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); @(negedge clk);
      check("end_busy", busy, 0);
      check("end_ack",  {ack1, ack0}, 0);
      check("end_we",   mem_write_enable, 0);
      check("end_mem",  mem[e_a], exp_mem[e_a]);
   endtask

   initial begin
      reset_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = 4'h0; addr1 = 4'h0; wdata0 = 4'h0; wdata1 = 4'h0;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      reset_n = 1'b1;

      // Single write then read-back from the other port.
      run_txn(1, 0, 1, 0, 4'h0, 4'h0, 4'hA, 4'h0, 0);
      run_txn(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      check("rb_rd1", rdata1, 4'hA);
      check("rb_rd0", rdata0, 4'h0);

      // Fields change during ACCESS; only the granted values may reach memory.
      run_txn(1, 0, 1, 0, 4'h1, 4'h0, 4'h5, 4'h0, 2);
      check("sag_loc1", mem[1], 4'h5);
      check("sag_loc2", mem[2], 4'h0);

      // Pointer now favours 1 after the grant to 0; lone req1 wins immediately.
      run_txn(0, 1, 0, 0, 4'h0, 4'h1, 4'h0, 4'h0, 0);
      check("lone_rd1", rdata1, 4'h5);
      run_txn(1, 1, 0, 1, 4'h1, 4'h3, 4'h0, 4'hC, 0);
      run_txn(1, 0, 0, 0, 4'h3, 4'h0, 4'h0, 4'h0, 0);

      for (int i = 0; i < 60; i++) begin
         run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1)));
      end

      // Reset in the middle of a write access.
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'h7; wdata0 = exp_mem[7] ^ 4'hF; req1 = 1'b0;
      @(posedge clk); @(negedge clk);
      check("mar_we_pre", mem_write_enable, 1);
      req0 = 1'b0;
      reset_n = 1'b0;
      #1;
      check_reset_vals("mar");
      @(posedge clk); @(negedge clk);
      check("mar_ack", {ack1, ack0}, 0);
      check("mar_mem", mem[7], exp_mem[7]);
      pref = 0;
      exp_rd[0] = 4'h0; exp_rd[1] = 4'h0;
      reset_n = 1'b1;
      run_txn(1, 1, 0, 0, 4'h7, 4'h0, 4'h0, 4'h0, 0);

      // Contention: both requests held from reset, acks every 3 cycles, alternating.
      reset_n = 1'b0;
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 4'h1; addr1 = 4'h3;
      pref = 0;
      exp_rd[0] = 4'h0; exp_rd[1] = 4'h0;
      @(negedge clk);
      check_reset_vals("crst");
      reset_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         int w;
         @(posedge clk); @(negedge clk);
         w = -1;
         if (k % 3 == 2) begin
            w = pref;
            pref = 1 - w;
            exp_rd[w] = exp_mem[(w == 1) ? 3 : 1];
         end
         check("con_ack0", ack0, w == 0);
         check("con_ack1", ack1, w == 1);
         check("con_excl", ack0 & ack1, 0);
         if (w >= 0) check("con_rd", (w == 1) ? rdata1 : rdata0, exp_rd[w]);
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      check("con_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, meaning memory address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 4, meaning memory data width in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports req0/req1, input, 1 each, meaning the requester asks for one memory access.
REQ-006 The block SHALL have ports we0/we1, input, 1 each, meaning 1 = write, 0 = read.
REQ-007 The block SHALL have ports addr0/addr1, input, ADDR_W each, meaning the access address.
REQ-008 The block SHALL have ports wdata0/wdata1, input, DATA_W each, meaning the write data.
REQ-009 The block SHALL have ports ack0/ack1, output, 1 each, meaning a one-cycle completion pulse.
REQ-010 The block SHALL have ports rdata0/rdata1, output, DATA_W each, meaning the read result, valid with ack.
REQ-011 The block SHALL have port busy, output, 1, meaning the FSM is not IDLE.
REQ-012 The block SHALL have ports mem_address (output, ADDR_W), mem_data_in (output, DATA_W), mem_write_enable (output, 1) and mem_data_out (input, DATA_W), which connect to the memory unit.

Function
REQ-013 The FSM SHALL have states IDLE, ACCESS and RESPOND, encoded in 2 bits.
REQ-014 In IDLE with any reqN high, the FSM SHALL grant one requester, capture its we/addr/wdata into internal registers, and go to ACCESS on the next edge.
REQ-015 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; after reset, requester 0 is preferred.
REQ-016 With a single request high, that requester SHALL win regardless of the round-robin pointer.
REQ-017 The round-robin pointer SHALL update only on grant.
REQ-018 In ACCESS, the block SHALL drive the captured address and data onto mem_address and mem_data_in, assert mem_write_enable for exactly that one cycle if the captured we=1, and go to RESPOND.
REQ-019 In RESPOND, the block SHALL pulse ackN of the granted requester for one cycle, load rdataN with mem_data_out on a read (leave it unchanged on a write), and return to IDLE.
REQ-020 Latency SHALL be as follows: a request sampled in IDLE at edge N produces mem_write_enable during cycle N+1 and ackN during cycle N+2; each access takes 3 cycles.
REQ-021 rdataN SHALL hold its value until the next read ack to the same port.
REQ-022 Requester fields SHALL be sampled only at grant; changes or deassertion of reqN after grant SHALL NOT abort or alter the access.
REQ-023 A requester that keeps reqN high through its ack SHALL be treated as a new request in the following IDLE cycle.
REQ-024 ack0 and ack1 SHALL never be high in the same cycle.
REQ-025 Outside ACCESS, mem_write_enable SHALL be 0; mem_address and mem_data_in SHALL hold the captured values.
REQ-026 busy SHALL be 1 in ACCESS and RESPOND and 0 in IDLE.

Reset
REQ-027 While reset_n=0, the block SHALL be asynchronously forced to: state IDLE, pointer favouring requester 0, ack0=ack1=0, busy=0, mem_write_enable=0, mem_address=0, mem_data_in=0, rdata0=rdata1=0.
REQ-028 A reset asserted mid-access SHALL abandon the access with no ack, and SHALL drop mem_write_enable immediately.
REQ-029 After reset_n rises, the first arbitration SHALL occur on the first rising edge.

Structure
REQ-030 State encodings (IDLE=0, ACCESS=1, RESPOND=2) and the default widths SHALL live in a shared package, memory_pkg.
REQ-031 The round-robin selector (two req inputs, pointer, one-hot grant output) SHALL be a sub-module, rr_arbiter2.
REQ-032 The memory unit SHALL be instantiated outside the block, in the testbench or top level, not inside memory_arbiter.

Verification
REQ-033 Single write: req0=1, we0=1, addr0=4'h0, wdata0=4'hA -> mem_write_enable high for one cycle, one cycle after grant; ack0 two cycles after grant.
REQ-034 Read-back: req1=1, we1=0, addr1=4'h0 after the write above -> ack1 with rdata1=4'hA; rdata0 unchanged.
REQ-035 Contention: req0 and req1 held high from reset -> grants in order 0,1,0,1; each ack is 3 cycles apart; acks are never coincident.
REQ-036 Sample-at-grant: write addr0=4'h1, wdata0=4'h5, then change addr0 to 4'h2 during ACCESS -> memory location 1 holds 4'h5 and location 2 is untouched.
REQ-037 Mid-access reset: reset_n=0 during ACCESS -> mem_write_enable=0 and busy=0 at once, no ack is issued, and all outputs hold their reset values.
REQ-038 Lone requester: only req1 high, with the pointer favouring requester 1 after a prior grant to 0 -> requester 1 is granted at the very next IDLE edge.
